// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus arbiter:
// command bytes, init ROM, FSM states and helpers.
package lcd_pkg;

   localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
   localparam logic [7:0] DISP_ON       = 8'h0C;
   localparam logic [7:0] ENTRY_INC     = 8'h06;
   localparam logic [7:0] CLEAR         = 8'h01;
   localparam logic [7:0] HOME          = 8'h02;

   localparam int INIT_LEN = 4;

   typedef enum logic [2:0] {
      PWRUP,
      INIT_LOAD,
      IDLE,
      SETUP,
      PULSE,
      WAIT
   } lcd_state_e;

   // Clear and both home encodings need the long settle time
   function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == CLEAR || data == HOME || data == 8'h03);
   endfunction

   function automatic logic [7:0] init_rom(input logic [1:0] k);
      case (k)
         2'd0:    return FUNC_SET_8B2L;
         2'd1:    return DISP_ON;
         2'd2:    return ENTRY_INC;
         default: return CLEAR;
      endcase
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by the power-up, enable-pulse
// and settle phases. Holds at 1 once expired.
module lcd_delay_timer #(
   parameter int W       = 21,
   parameter int RST_VAL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load on phase entry, otherwise count down and stop at 1
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q > W'(1)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register; reset starts the power-up delay
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= W'(RST_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Owns the 8-bit character-LCD bus: runs the init sequence,
// then round-robin grants single-byte writes from NREQ clients.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int EN_CYCLES  = 25,
   parameter int CMD_WAIT   = 2500,
   parameter int CLR_WAIT   = 100000,
   parameter int PWRUP_WAIT = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_rs,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              busy,
   output logic              init_done,
   output logic [7:0]        lcd_data,
   output logic              lcd_rs,
   output logic              lcd_en
);

   localparam int TW = $clog2(imax(imax(PWRUP_WAIT, CLR_WAIT),
                                   imax(CMD_WAIT, EN_CYCLES)) + 1);

   lcd_state_e  state_q;
   logic [1:0]  idx_q;
   logic [1:0]  rr_q;
   logic        init_done_q;
   logic        en_q;
   logic        rs_q;
   logic [7:0]  data_q;

   logic          tload;
   logic          tdone;
   logic [TW-1:0] tval;

   logic [3:0] vld_x;
   logic [3:0] rs_x;
   logic [7:0] dat_x [4];
   logic       gnt_any;
   logic [1:0] gidx;
   logic [1:0] rr_nxt;
   logic [2:0] sum;
   logic [3:0] oh;

   lcd_delay_timer #(
      .W       (TW),
      .RST_VAL (PWRUP_WAIT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load_i  (tload),
      .value_i (tval),
      .done_o  (tdone)
   );

   // Widen the request bundle to four lanes for uniform indexing
   always_comb begin
      vld_x = '0;
      rs_x  = '0;
      for (int i = 0; i < 4; i++) dat_x[i] = '0;
      for (int i = 0; i < NREQ; i++) begin
         vld_x[i] = req_valid[i];
         rs_x[i]  = req_rs[i];
         dat_x[i] = req_data[8*i +: 8];
      end
   end

   // Round-robin search: first valid lane at or after rr_q
   always_comb begin
      gnt_any = 1'b0;
      gidx    = '0;
      sum     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_q} + 3'(k);
         if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
         if (!gnt_any && vld_x[sum[1:0]]) begin
            gnt_any = 1'b1;
            gidx    = sum[1:0];
         end
      end
   end

   assign rr_nxt = (gidx == 2'(NREQ - 1)) ? 2'd0 : gidx + 2'd1;
   assign oh     = 4'b0001 << gidx;

   // Timer loads: pulse width on SETUP exit, settle on PULSE exit
   always_comb begin
      tload = 1'b0;
      tval  = TW'(EN_CYCLES);
      if (state_q == SETUP) begin
         tload = 1'b1;
      end else if (state_q == PULSE && tdone) begin
         tload = 1'b1;
         tval  = is_slow_cmd(rs_q, data_q) ? TW'(CLR_WAIT)
                                            : TW'(CMD_WAIT);
      end
   end

   // Main sequencer; ROM fetch happens on the cycle before SETUP
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PWRUP;
         idx_q       <= '0;
         rr_q        <= '0;
         init_done_q <= 1'b0;
         en_q        <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= '0;
      end else begin
         unique case (state_q)
            PWRUP: begin
               if (tdone) begin
                  state_q <= SETUP;
                  idx_q   <= '0;
                  data_q  <= init_rom(2'd0);
                  rs_q    <= 1'b0;
               end
            end
            INIT_LOAD: begin
               state_q <= SETUP;
               data_q  <= init_rom(idx_q);
               rs_q    <= 1'b0;
            end
            IDLE: begin
               if (gnt_any) begin
                  state_q <= SETUP;
                  data_q  <= dat_x[gidx];
                  rs_q    <= rs_x[gidx];
                  rr_q    <= rr_nxt;
               end
            end
            SETUP: begin
               state_q <= PULSE;
               en_q    <= 1'b1;
            end
            PULSE: begin
               if (tdone) begin
                  state_q <= WAIT;
                  en_q    <= 1'b0;
               end
            end
            WAIT: begin
               if (tdone) begin
                  if (!init_done_q && idx_q != 2'(INIT_LEN - 1)) begin
                     state_q <= SETUP;
                     idx_q   <= idx_q + 2'd1;
                     data_q  <= init_rom(idx_q + 2'd1);
                     rs_q    <= 1'b0;
                  end else begin
                     state_q     <= IDLE;
                     init_done_q <= 1'b1;
                  end
               end
            end
            default: state_q <= PWRUP;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE && gnt_any) ? oh[NREQ-1:0] : '0;
   assign busy      = (state_q != IDLE);
   assign init_done = init_done_q;
   assign lcd_data  = data_q;
   assign lcd_rs    = rs_q;
   assign lcd_en    = en_q;

endmodule
